cnn_layer_accel_seq_gen: RTL and testbench

- Hardware generator for the per-column sequence words consumed by cnn_layer_accel_octo.
- Replaces the host/bench-built sequence table with a run-time-configured streaming source.
- Generalised in column count, words per column, bank offset and field widths.
- Drives the accelerator's shared datain bus under the seq_datain_tag / seq_datain_rdy handshake and reports the table size it produced.

---
 rtl/cnn_layer_accel_seq_gen.sv | 170 +++++++++++++++++
 tb/tb_cnn_layer_accel_seq_gen.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_seq_gen.sv
// Streaming generator of per-column sequence words for cnn_layer_accel_octo.
// Word layout is {S, RM, RST, P, seq}, MSB first. Each word is produced from the
// current (column, word) indices using a closed form.
module cnn_layer_accel_seq_gen #(
  parameter int unsigned C_SEQ_FIELD_WIDTH = 10,
  parameter int unsigned C_SEQ_DATA_WIDTH  = C_SEQ_FIELD_WIDTH + 4,
  parameter int unsigned C_WORDS_PER_COL   = 5,
  parameter int unsigned C_BANK_OFFSET     = 512,
  parameter int unsigned C_MAX_COLS        = 1024
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  input  logic                                                abort,
  input  logic [$clog2(C_MAX_COLS)-1:0]                       num_cols_m1,
  output logic [C_SEQ_DATA_WIDTH-1:0]                         datain,
  output logic                                                datain_valid,
  output logic                                                seq_datain_tag,
  input  logic                                                seq_datain_rdy,
  output logic [$clog2(C_MAX_COLS*C_WORDS_PER_COL+1)-1:0]     seq_full_count,
  output logic                                                busy,
  output logic                                                done
);

  localparam int unsigned FW = C_SEQ_FIELD_WIDTH;
  localparam int unsigned DW = C_SEQ_DATA_WIDTH;
  localparam int unsigned CW = $clog2(C_MAX_COLS);
  localparam int unsigned NW = $clog2(C_MAX_COLS*C_WORDS_PER_COL+1);
  localparam int unsigned KW = $clog2(C_WORDS_PER_COL);

  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [CW-1:0]   cols_m1_q, cols_m1_d;
  logic [KW-1:0]   word_q, word_d;
  logic [DW-1:0]   datain_d;
  logic            valid_d;
  logic            busy_d;
  logic            done_d;
  logic [NW-1:0]   count_d;
  logic            last_word_c;
  logic            last_col_c;

  // Closed-form sequence word for column c, word k (seq arithmetic wraps at 2^FW).
  function automatic logic [DW-1:0] gen_word(input logic [CW-1:0] c, input logic [KW-1:0] k);
    logic          s;
    logic          rm;
    logic          rs;
    logic          p;
    logic [FW-1:0] seq;
    s   = 1'b0;
    rm  = (k == KW'(C_WORDS_PER_COL - 1));
    rs  = 1'b0;
    p   = 1'b0;
    seq = '0;
    if (k == '0) begin
      rs  = 1'b1;
      seq = FW'(c);
      if (c == '0) begin
        p = 1'b1;
      end else begin
        s = 1'b1;
        p = ~c[0];
      end
    end else if (k == KW'(1)) begin
      p   = c[0];
      seq = FW'({c[CW-1:1], 1'b0}) + FW'(2);
    end else begin
      s   = (c == '0) && (k == KW'(2));
      seq = FW'(C_BANK_OFFSET) + FW'(k) - FW'(2) + FW'(c);
    end
    return DW'({s, rm, rs, p, seq});
  endfunction

  assign last_word_c = (word_q == KW'(C_WORDS_PER_COL - 1));
  assign last_col_c  = (col_q == cols_m1_q);

  // Next-state and next-output logic; abort takes priority over a same-cycle transfer.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    word_d    = word_q;
    cols_m1_d = cols_m1_q;
    datain_d  = datain;
    valid_d   = datain_valid;
    busy_d    = busy;
    done_d    = 1'b0;
    count_d   = seq_full_count;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = STREAM;
          cols_m1_d = num_cols_m1;
          col_d     = '0;
          word_d    = '0;
          datain_d  = gen_word('0, '0);
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          count_d   = NW'((NW'(num_cols_m1) + NW'(1)) * NW'(C_WORDS_PER_COL));
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (datain_valid && seq_datain_rdy) begin
          if (last_col_c && last_word_c) begin
            state_d = FIN;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            if (last_word_c) begin
              col_d  = col_q + CW'(1);
              word_d = '0;
            end else begin
              word_d = word_q + KW'(1);
            end
            datain_d = gen_word(col_d, word_d);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q          <= '0;
      word_q         <= '0;
      cols_m1_q      <= '0;
      datain         <= '0;
      datain_valid   <= 1'b0;
      seq_datain_tag <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      seq_full_count <= '0;
    end else begin
      col_q          <= col_d;
      word_q         <= word_d;
      cols_m1_q      <= cols_m1_d;
      datain         <= datain_d;
      datain_valid   <= valid_d;
      seq_datain_tag <= valid_d;
      busy           <= busy_d;
      done           <= done_d;
      seq_full_count <= count_d;
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_seq_gen.sv
// Scoreboard bench for cnn_layer_accel_seq_gen: default instance plus a W=3 / offset 1022 instance.
module tb_cnn_layer_accel_seq_gen;

  localparam int unsigned FW = 10;
  localparam int unsigned DW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          start3 = 1'b0;
  logic          abort = 1'b0;
  logic          rdy = 1'b0;
  logic [9:0]    num_cols_m1 = '0;

  logic [DW-1:0] datain0, datain3;
  logic          valid0, valid3, tag0, tag3, busy0, busy3, done0, done3;
  logic [12:0]   count0;
  logic [11:0]   count3;

  logic          sel3 = 1'b0;
  logic [DW-1:0] cur_datain;
  logic          cur_valid, cur_tag, cur_done;

  int            n_checks = 0;
  int            n_fail = 0;
  int            xfer_cnt = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] got[int];

  always #5 clk = ~clk;

  cnn_layer_accel_seq_gen dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_cols_m1(num_cols_m1),
    .datain(datain0), .datain_valid(valid0), .seq_datain_tag(tag0), .seq_datain_rdy(rdy),
    .seq_full_count(count0), .busy(busy0), .done(done0)
  );

  cnn_layer_accel_seq_gen #(.C_WORDS_PER_COL(3), .C_BANK_OFFSET(1022)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort), .num_cols_m1(num_cols_m1),
    .datain(datain3), .datain_valid(valid3), .seq_datain_tag(tag3), .seq_datain_rdy(rdy),
    .seq_full_count(count3), .busy(busy3), .done(done3)
  );

  assign cur_datain = sel3 ? datain3 : datain0;
  assign cur_valid  = sel3 ? valid3 : valid0;
  assign cur_tag    = sel3 ? tag3 : tag0;
  assign cur_done   = sel3 ? done3 : done0;

  // Reference word: column c, word k, for a table of w words per column.
  function automatic logic [DW-1:0] model(input int c, input int k, input int w, input int off);
    int   seq;
    logic s, rm, rs, p;
    s = 1'b0; rm = (k == w - 1); rs = 1'b0; p = 1'b0; seq = 0;
    if (k == 0) begin
      rs = 1'b1;
      seq = c;
      if (c == 0) p = 1'b1;
      else begin s = 1'b1; p = ((c - 1) % 2) == 1; end
    end else if (k == 1) begin
      seq = 2 + 2 * (c / 2);
      p = (c % 2) == 1;
    end else begin
      seq = off + (k - 2) + c;
      s = (c == 0) && (k == 2);
    end
    return {s, rm, rs, p, FW'(seq)};
  endfunction

  // Scoreboard consumer: every accepted word is popped and compared.
  always @(negedge clk) begin
    logic [DW-1:0] exp_w;
    if (rst === 1'b1) begin
      n_checks++;
      if (cur_tag !== cur_valid) begin
        n_fail++;
        $display("FAIL tag_eq_valid: tag=%b valid=%b", cur_tag, cur_valid);
      end
      if (cur_valid === 1'b1 && rdy === 1'b1 && abort !== 1'b1) begin
        got[xfer_cnt] = cur_datain;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: word %0d got %h, nothing expected", xfer_cnt, cur_datain);
        end else begin
          exp_w = sb.pop_front();
          if (cur_datain !== exp_w) begin
            n_fail++;
            $display("FAIL sb_word: word %0d got %h expected %h", xfer_cnt, cur_datain, exp_w);
          end
        end
        xfer_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic begin_run(input bit use3, input int ncm1, input int w, input int off);
    sel3 = use3;
    sb.delete();
    got.delete();
    xfer_cnt = 0;
    for (int c = 0; c <= ncm1; c++)
      for (int k = 0; k < w; k++)
        sb.push_back(model(c, k, w, off));
    num_cols_m1 = 10'(ncm1);
    if (use3) start3 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cyc);
    cyc = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (cur_done === 1'b1) begin
        cyc = i;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({datain0, valid0, tag0, busy0, done0, count0} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: d=%h v=%b t=%b b=%b dn=%b cnt=%0d required all 0",
               datain0, valid0, tag0, busy0, done0, count0);
    end
    tick();
    rst = 1'b1;
    rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (valid0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: valid=%b busy=%b required 0 0", valid0, busy0);
    end
  endtask

  task automatic test_stream();
    int            cyc;
    int            idx[6] = '{0, 2, 5, 6, 11, 49};
    logic [DW-1:0] vals[6] = '{14'h0C00, 14'h2200, 14'h2801, 14'h0402, 14'h0004, 14'h120B};
    tick();
    rdy = 1'b1;
    begin_run(1'b0, 9, 5, 512);
    wait_done(200, cyc);
    n_checks++;
    if (cyc != 51) begin n_fail++; $display("FAIL stream_done_latency: done at %0d required 51", cyc); end
    n_checks++;
    if (xfer_cnt != 50 || sb.size() != 0) begin
      n_fail++; $display("FAIL stream_count: xfers=%0d left=%0d required 50 0", xfer_cnt, sb.size());
    end
    n_checks++;
    if (count0 !== 13'd50) begin n_fail++; $display("FAIL stream_full_count: %0d required 50", count0); end
    n_checks++;
    if (busy0 !== 1'b0 || valid0 !== 1'b0) begin
      n_fail++; $display("FAIL stream_end_flags: busy=%b valid=%b required 0 0", busy0, valid0);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (!got.exists(idx[i]) || got[idx[i]] !== vals[i]) begin
        n_fail++;
        $display("FAIL stream_word%0d: got %h required %h", idx[i],
                 got.exists(idx[i]) ? got[idx[i]] : 14'h0, vals[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done0 !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: done=%b required 0", done0); end
  endtask

  task automatic test_backpressure();
    int            cyc;
    logic [DW-1:0] held;
    tick();
    rdy = 1'b1;
    begin_run(1'b0, 9, 5, 512);
    repeat (7) tick();
    rdy = 1'b0;
    held = '0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (j == 0) begin
        held = datain0;
        n_checks++;
        if (held !== model(1, 2, 5, 512)) begin
          n_fail++; $display("FAIL bp_word7: got %h required %h", held, model(1, 2, 5, 512));
        end
      end
      n_checks++;
      if (datain0 !== held || valid0 !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold: cycle %0d d=%h v=%b required %h 1", j, datain0, valid0, held);
      end
      tick();
    end
    rdy = 1'b1;
    wait_done(200, cyc);
    n_checks++;
    if (cyc < 0 || xfer_cnt != 50 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_total: done_cyc=%0d xfers=%0d left=%0d required >0 50 0", cyc, xfer_cnt, sb.size());
    end
  endtask

  task automatic test_abort();
    int cyc;
    tick();
    rdy = 1'b1;
    begin_run(1'b0, 9, 5, 512);
    repeat (20) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if (valid0 !== 1'b0 || tag0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_flags: v=%b t=%b b=%b dn=%b required 0 0 0 0", valid0, tag0, busy0, done0);
    end
    n_checks++;
    if (xfer_cnt != 20) begin n_fail++; $display("FAIL abort_xfers: %0d required 20", xfer_cnt); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_checks++;
      if (done0 !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: done=%b required 0", done0); end
    end
    tick();
    begin_run(1'b0, 9, 5, 512);
    wait_done(200, cyc);
    n_checks++;
    if (cyc != 51 || xfer_cnt != 50 || !got.exists(0) || got[0] !== 14'h0C00) begin
      n_fail++;
      $display("FAIL abort_restart: cyc=%0d xfers=%0d w0=%h required 51 50 0c00", cyc, xfer_cnt,
               got.exists(0) ? got[0] : 14'h0);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    rdy = 1'b1;
    begin_run(1'b0, 9, 5, 512);
    repeat (10) tick();
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({datain0, valid0, tag0, busy0, done0, count0} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: d=%h v=%b t=%b b=%b dn=%b cnt=%0d required all 0",
               datain0, valid0, tag0, busy0, done0, count0);
    end
    tick();
    tick();
    sb.delete();
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_checks++;
      if (valid0 !== 1'b0 || busy0 !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_idle: v=%b b=%b required 0 0", valid0, busy0);
      end
    end
  endtask

  task automatic test_wrap();
    int cyc;
    tick();
    rdy = 1'b1;
    begin_run(1'b1, 3, 3, 1022);
    wait_done(100, cyc);
    n_checks++;
    if (cyc != 13 || xfer_cnt != 12 || sb.size() != 0 || count3 !== 12'd12 || busy3 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_count: cyc=%0d xfers=%0d left=%0d cnt=%0d busy=%b required 13 12 0 12 0",
               cyc, xfer_cnt, sb.size(), count3, busy3);
    end
    n_checks++;
    if (!got.exists(2) || got[2] !== 14'h33FE) begin
      n_fail++; $display("FAIL wrap_c0w2: got %h required 33fe", got.exists(2) ? got[2] : 14'h0);
    end
    n_checks++;
    if (!got.exists(8) || got[8] !== 14'h1000) begin
      n_fail++; $display("FAIL wrap_c2w2: got %h required 1000", got.exists(8) ? got[8] : 14'h0);
    end
    sel3 = 1'b0;
  endtask

  task automatic test_start_held();
    int cyc;
    tick();
    rdy = 1'b1;
    begin_run(1'b0, 0, 5, 512);
    start = 1'b1;
    wait_done(50, cyc);
    start = 1'b0;
    n_checks++;
    if (cyc != 6 || xfer_cnt != 5 || sb.size() != 0 || count0 !== 13'd5) begin
      n_fail++;
      $display("FAIL start_held: cyc=%0d xfers=%0d left=%0d cnt=%0d required 6 5 0 5",
               cyc, xfer_cnt, sb.size(), count0);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (valid0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL start_held_idle: v=%b b=%b required 0 0", valid0, busy0);
    end
  endtask

  task automatic test_max_cols();
    int cyc;
    tick();
    rdy = 1'b1;
    begin_run(1'b0, 1023, 5, 512);
    n_checks++;
    if (count0 !== 13'd5120) begin n_fail++; $display("FAIL max_full_count: %0d required 5120", count0); end
    wait_done(6000, cyc);
    n_checks++;
    if (cyc != 5121 || xfer_cnt != 5120 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL max_cols_run: cyc=%0d xfers=%0d left=%0d required 5121 5120 0", cyc, xfer_cnt, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_wrap();
    test_start_held();
    test_max_cols();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
